// File: rtl/pe_acc_stage_pkg.sv
// Shared PE definitions: mode and accumulation-state encodings plus a
// width-generic saturating signed add.
package pe_acc_stage_pkg;

   typedef enum logic [1:0] {
      GEMM = 2'b00,
      DIV  = 2'b01,
      EXP  = 2'b10,
      LOG  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      HOLD = 2'b10
   } state_e;

   localparam int unsigned SAT_MAX_BW = 64;

   // Operands arrive sign-extended to SAT_MAX_BW; bw is the real datapath width.
   // Result is {ovf, sum} with sum clamped to the signed bw-bit range.
   function automatic logic [SAT_MAX_BW:0] sat_add_f(
      input logic signed [SAT_MAX_BW-1:0] a,
      input logic signed [SAT_MAX_BW-1:0] b,
      input int unsigned                  bw
   );
      logic signed [SAT_MAX_BW:0] s;
      logic signed [SAT_MAX_BW:0] hi;
      logic signed [SAT_MAX_BW:0] lo;
      logic                       ovf;
      logic [SAT_MAX_BW-1:0]      r;
      s   = (SAT_MAX_BW+1)'(a) + (SAT_MAX_BW+1)'(b);
      hi  = (65'sd1 <<< (bw - 1)) - 65'sd1;
      lo  = -(65'sd1 <<< (bw - 1));
      ovf = 1'b0;
      r   = s[SAT_MAX_BW-1:0];
      if (s > hi) begin
         ovf = 1'b1;
         r   = hi[SAT_MAX_BW-1:0];
      end else if (s < lo) begin
         ovf = 1'b1;
         r   = lo[SAT_MAX_BW-1:0];
      end
      return {ovf, r};
   endfunction

endpackage

// File: rtl/pe_acc_stage_sat_add.sv
// ACC_BW-wide saturating signed adder with overflow flag, shared by PE stages.
module pe_acc_stage_sat_add
   import pe_acc_stage_pkg::*;
#(
   parameter int unsigned ACC_BW = 32
) (
   input  logic [ACC_BW-1:0] i_a,
   input  logic [ACC_BW-1:0] i_b,
   output logic [ACC_BW-1:0] o_sum,
   output logic              o_ovf
);

   logic [SAT_MAX_BW:0]        w_res;
   logic [SAT_MAX_BW-1:ACC_BW] w_unused_ext;

   assign w_res = sat_add_f(SAT_MAX_BW'(signed'(i_a)),
                            SAT_MAX_BW'(signed'(i_b)),
                            ACC_BW);

   // Bits above ACC_BW are only sign copies of the clamped result.
   assign w_unused_ext = w_res[SAT_MAX_BW-1:ACC_BW];
   assign o_sum        = w_res[ACC_BW-1:0];
   assign o_ovf        = w_res[SAT_MAX_BW];

endmodule

// File: rtl/pe_acc_stage.sv
// PE accumulation stage: product + offset on the first beat, then saturating
// accumulation of further products, result held on a valid/ready output.
module pe_acc_stage
   import pe_acc_stage_pkg::*;
#(
   parameter int unsigned MUL_BW = 16,
   parameter int unsigned ACC_BW = 32,
   parameter int unsigned CNT_BW = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            gemm_uno,
   input  logic [CNT_BW-1:0]     len_i,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*MUL_BW-1:0]   prod_i,
   input  logic [ACC_BW-1:0]     offset_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_BW-1:0]     acc_o,
   output logic                  ovf_o
);

   localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [ACC_BW-1:0]   r_acc;
   logic                r_ovf;
   logic [CNT_BW-1:0]   r_cnt;
   logic [CNT_BW-1:0]   r_target;

   logic                w_beat;
   logic                w_first;
   logic                w_acc_beat;
   logic [CNT_BW-1:0]   w_target_first;
   logic [CNT_BW-1:0]   w_cnt_inc;
   logic [ACC_BW-1:0]   w_prod_ext;
   logic [ACC_BW-1:0]   w_add_a;
   logic [ACC_BW-1:0]   w_add_b;
   logic [ACC_BW-1:0]   w_sum;
   logic                w_sum_ovf;

   assign in_ready   = (r_state != HOLD) || out_ready;
   assign w_beat     = in_valid && in_ready;
   // A beat taken in HOLD implies out_ready, so it retires the result and starts anew.
   assign w_first    = w_beat && (r_state != ACC);
   assign w_acc_beat = w_beat && (r_state == ACC);
   assign w_cnt_inc  = r_cnt + CNT_ONE;
   assign w_prod_ext = ACC_BW'(signed'(prod_i));

   always_comb begin
      w_target_first = CNT_ONE;
      if (mode_e'(gemm_uno) == GEMM && len_i != '0) begin
         w_target_first = len_i;
      end
   end

   assign w_add_a = w_first ? w_prod_ext : r_acc;
   assign w_add_b = w_first ? offset_i   : w_prod_ext;

   pe_acc_stage_sat_add #(
      .ACC_BW (ACC_BW)
   ) u_sat_add (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .o_sum (w_sum),
      .o_ovf (w_sum_ovf)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_first) begin
               w_state_nxt = (w_target_first == CNT_ONE) ? HOLD : ACC;
            end
         end
         ACC: begin
            if (w_acc_beat && w_cnt_inc == r_target) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_first) begin
               w_state_nxt = (w_target_first == CNT_ONE) ? HOLD : ACC;
            end else if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
         r_target <= '0;
      end else if (w_first) begin
         r_acc    <= w_sum;
         r_ovf    <= w_sum_ovf;
         r_cnt    <= CNT_ONE;
         r_target <= w_target_first;
      end else if (w_acc_beat) begin
         r_acc    <= w_sum;
         r_ovf    <= r_ovf | w_sum_ovf;
         r_cnt    <= w_cnt_inc;
      end
   end

   assign out_valid = (r_state == HOLD);
   assign acc_o     = r_acc;
   assign ovf_o     = r_ovf;

endmodule

// File: doc/pe_acc_stage.md
Name: pe_acc_stage

Overview:
- Accumulation stage of the PE, directly downstream of the offset generator and the PE multiplier.
- Adds the registered offset (nonzero only in log mode) to the multiplier product, then accumulates further products for GEMM dot-products.
- Saturates on overflow and presents the result on a valid/ready output.
- Input-side alignment of product and offset (same beat) is the upstream pipeline's responsibility.

Parameters:
MUL_BW, 16, multiplier operand width; product width is 2*MUL_BW
ACC_BW, 32, accumulator and offset width; must be >= 2*MUL_BW
CNT_BW, 8, beat-counter width; max dot-product length 2^CNT_BW-1

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  reset, synchronous, active-low
gemm_uno  input  2  00 gemm, 01 div, 10 exp, 11 log; sampled on first beat only
len_i  input  CNT_BW  number of product beats; sampled on first beat only
in_valid  input  1  prod_i/offset_i valid
in_ready  output  1  stage can accept a beat
prod_i  input  2*MUL_BW  signed multiplier product
offset_i  input  ACC_BW  signed offset from offset generator
out_valid  output  1  acc_o/ovf_o valid
out_ready  input  1  consumer accepts result
acc_o  output  ACC_BW  signed accumulated result
ovf_o  output  1  sticky saturation flag for this result

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, acc_o=0, ovf_o=0, out_valid=0, beat count=0. Reset mid-accumulation discards partial sum; no output produced.
- States: IDLE, ACC, HOLD.
- in_ready = (state!=HOLD) || out_ready. Beat accepted when in_valid && in_ready.
- First beat (accepted in IDLE, or in HOLD while out_ready=1):
  - Latch mode and target length. Target = len_i, except len_i=0 is treated as 1. For non-gemm modes target is forced to 1.
  - acc = sat(sext(prod_i) + offset_i); ovf = overflow of that add.
  - count=1. If target==1 go HOLD, else go ACC.
- ACC, accepted beat:
  - acc = sat(acc + sext(prod_i)); offset_i ignored; ovf |= overflow; count++.
  - When count reaches target go HOLD.
  - No beat: hold state and values.
- HOLD: out_valid=1; acc_o/ovf_o stable until accepted.
  - out_ready=1 and no in_valid -> IDLE, out_valid=0 next cycle.
  - out_ready=1 with in_valid -> result retires and the new beat is processed as a first beat in the same cycle (no bubble).
- Latency: len=1 beat accepted at cycle t gives out_valid at t+1. N beats, last accepted at t gives out_valid at t+1.
- Arithmetic:
  - prod_i is sign-extended to ACC_BW; sums use ACC_BW+1 bits.
  - Overflow when the top two sum bits differ: clamp to +(2^(ACC_BW-1)-1) or -2^(ACC_BW-1).
- gemm_uno and len_i changes during ACC are ignored.
- Count never wraps: the maximum target is 2^CNT_BW-1.

Decomposition:
- Shared PE package: mode enum (GEMM, DIV, EXP, LOG = 2'b00..2'b11) and state enum (IDLE, ACC, HOLD).
- Package function for saturating signed add returning {ovf, sum}.
- One natural sub-module: sat_add (ACC_BW-wide saturating adder with overflow flag), reusable by other PE stages.

Test Plan:
- Log single beat: mode=11, prod_i=0x00000200, offset_i=0x00001000 -> one cycle later out_valid=1, acc_o=0x00001200, ovf_o=0.
- GEMM len=4: prods 3, -5, 10, 7 with offset_i=0, back-to-back -> out_valid 1 cycle after 4th beat, acc_o=15, ovf_o=0; in_ready stays 1 throughout.
- Backpressure: result in HOLD with out_ready=0 for 5 cycles -> acc_o stable, in_ready=0; then out_ready=1 with in_valid (div, prod_i=9) -> next cycle acc_o=9, out_valid=1.
- Saturation: gemm len=2, prods 0x7FFFFFF0 then 0x00000100 -> acc_o=0x7FFFFFFF, ovf_o=1. Repeat with negative operands -> acc_o=0x80000000, ovf_o=1.
- len_i=0 in gemm and len_i=5 in exp mode -> each completes after one beat.
- Reset mid-operation: gemm len=8, rst_n low after 3 beats -> next cycle out_valid=0, acc_o=0, in_ready=1. A fresh len=1 beat (prod_i=4) then yields acc_o=4.
